// File: rtl/recv_clk_if.sv
// recv_clk_if: consumer-side bundle of the UART receiver.
//   char     received byte            (receiver -> consumer)
//   valid    char holds an unacked byte
//   ferr     stop bit of char was bad
//   overrun  a byte was lost before being acknowledged
//   busy     receiver is inside a frame
//   ack      consumer has taken char   (consumer -> receiver)
interface recv_clk_if;
    logic [7:0] char;
    logic       valid;
    logic       ferr;
    logic       overrun;
    logic       busy;
    logic       ack;

    modport master (
        output char, valid, ferr, overrun, busy,
        input  ack
    );

    modport slave (
        input  char, valid, ferr, overrun, busy,
        output ack
    );
endinterface

// File: rtl/recv_clk.sv
// recv_clk: UART receive stage, far-end partner of the transmitter.
// Oversamples the line on the shared baud tick, validates the start bit,
// majority-votes each bit from three mid-bit samples and presents the byte
// through a valid/ack handshake.  Frame: idle, start, 8 data LSB first, 1 stop.
// Ports:
//   clk    system clock, all state on rising edge
//   reset  asynchronous active-low reset
//   rxpin  asynchronous serial input
//   baud   one-clk tick at OVERSAMPLE x bit rate
//   rx     byte/handshake bundle (char, valid, ferr, overrun, busy, ack)
module recv_clk #(
    parameter logic IDLELEVEL  = 1'b1,
    parameter logic DATAINV    = 1'b0,
    parameter int   OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxpin,
    input  logic       baud,
    recv_clk_if.master rx
);
    localparam int            TW    = $clog2(OVERSAMPLE);
    localparam int            MID   = OVERSAMPLE / 2;
    localparam logic [TW-1:0] T_S0  = TW'(MID - 1);
    localparam logic [TW-1:0] T_S1  = TW'(MID);
    localparam logic [TW-1:0] T_DEC = TW'(MID + 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

    localparam logic [4:0] S_IDLE  = 5'b00001;
    localparam logic [4:0] S_START = 5'b00010;
    localparam logic [4:0] S_DATA  = 5'b00100;
    localparam logic [4:0] S_STOP  = 5'b01000;
    localparam logic [4:0] S_BREAK = 5'b10000;

    logic          sync1, sync2, line;
    logic [4:0]    state;
    logic [TW-1:0] tcnt;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          smp_a, smp_b, maj;
    logic          at_dec, at_end, complete;

    // Synchroniser resets to the idle pin level so a release of reset on an
    // idle line is never mistaken for a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= IDLELEVEL ^ DATAINV;
            sync2 <= IDLELEVEL ^ DATAINV;
        end else begin
            sync1 <= rxpin;
            sync2 <= sync1;
        end
    end

    assign line = sync2 ^ DATAINV;

    // The first two votes are held; the third is the live line on the
    // decision tick, so the decision needs no extra pipeline stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            smp_a <= 1'b0;
            smp_b <= 1'b0;
        end else if (baud) begin
            if (tcnt == T_S0) smp_a <= line;
            if (tcnt == T_S1) smp_b <= line;
        end
    end

    assign maj      = (smp_a & smp_b) | (smp_a & line) | (smp_b & line);
    assign at_dec   = baud && (tcnt == T_DEC);
    assign at_end   = (tcnt == T_END);
    assign complete = at_dec && (state == S_STOP);

    // tcnt is the index of the tick being processed; the start-detect tick
    // is index 0 of the start bit, hence the load of 1 on leaving IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            tcnt   <= '0;
            bitcnt <= '0;
            shreg  <= '0;
        end else if (baud) begin
            case (state)
                S_IDLE: begin
                    tcnt <= '0;
                    if (line == ~IDLELEVEL) begin
                        state <= S_START;
                        tcnt  <= TW'(1);
                    end
                end
                S_START: begin
                    if (at_dec && (maj == IDLELEVEL)) begin
                        state <= S_IDLE;
                        tcnt  <= '0;
                    end else if (at_end) begin
                        state  <= S_DATA;
                        tcnt   <= '0;
                        bitcnt <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (at_dec) shreg <= {maj, shreg[7:1]};
                    if (at_end) begin
                        tcnt   <= '0;
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) state <= S_STOP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (at_dec) begin
                        tcnt  <= '0;
                        state <= (maj == IDLELEVEL) ? S_IDLE : S_BREAK;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    tcnt <= '0;
                    if (line == IDLELEVEL) state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    tcnt  <= '0;
                end
            endcase
        end
    end

    // Completion wins over ack: a coincident ack consumes the old byte, so
    // the new one stays valid and nothing is counted as lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx.char    <= '0;
            rx.valid   <= 1'b0;
            rx.ferr    <= 1'b0;
            rx.overrun <= 1'b0;
        end else if (complete) begin
            rx.char    <= shreg;
            rx.valid   <= 1'b1;
            rx.ferr    <= (maj != IDLELEVEL);
            rx.overrun <= rx.valid & ~rx.ack;
        end else if (rx.ack) begin
            rx.valid   <= 1'b0;
            rx.overrun <= 1'b0;
        end
    end

    assign rx.busy = (state != S_IDLE);
endmodule

// File: tb/tb_recv_clk.sv
module tb_recv_clk;
    localparam logic IL = 1'b1;
    localparam logic DI = 1'b1;
    localparam int   OS = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    logic clk, rst_n, rxpin, baud;
    logic mon_ack, man_ack, sb_en;
    int   div;
    int   bcnt;
    int   checks, failures;
    exp_t sb[$];

    recv_clk_if rif();
    assign rif.ack = mon_ack | man_ack;

    recv_clk #(.IDLELEVEL(IL), .DATAINV(DI), .OVERSAMPLE(OS)) dut (
        .clk   (clk),
        .reset (rst_n),
        .rxpin (rxpin),
        .baud  (baud),
        .rx    (rif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Baud tick every div clocks; div=1 ties it high.
    initial begin
        baud = 1'b0;
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (bcnt + 1 >= div) bcnt = 0;
            else bcnt++;
            baud = (bcnt == 0);
        end
    end

    // Monitor: every new valid is one completed byte, compared in order
    // against what the transmitter side queued; then acked after 0..3 clks.
    initial begin
        logic prev_valid;
        int   ack_wait;
        exp_t e;
        prev_valid = 1'b0;
        ack_wait   = -1;
        mon_ack    = 1'b0;
        forever begin
            @(negedge clk);
            mon_ack = 1'b0;
            if (!rst_n) begin
                prev_valid = 1'b0;
                ack_wait   = -1;
            end else begin
                if (sb_en && rif.valid && !prev_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL spurious_byte: got char 0x%0h expected no byte", rif.char);
                    end else begin
                        e = sb.pop_front();
                        chk("char", rif.char, e.data);
                        chk("ferr", rif.ferr, e.ferr);
                        chk("overrun", rif.overrun, 0);
                        chk("busy_at_valid", rif.busy, e.ferr);
                    end
                    ack_wait = $urandom_range(0, 3);
                end
                if (ack_wait == 0) begin
                    mon_ack  = 1'b1;
                    ack_wait = -1;
                end else if (ack_wait > 0) begin
                    ack_wait--;
                end
                prev_valid = rif.valid;
            end
        end
    end

    task automatic drive_bits(input logic v, input int nclk);
        rxpin = v ^ DI;
        repeat (nclk) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok,
                              input int gap_bits, input logic push);
        int bt;
        exp_t e;
        bt = OS * div;
        if (push) begin
            e.data = d;
            e.ferr = ~stop_ok;
            sb.push_back(e);
        end
        drive_bits(~IL, bt);
        for (int i = 0; i < 8; i++) drive_bits(d[i], bt);
        drive_bits(stop_ok ? IL : ~IL, bt);
        drive_bits(IL, gap_bits * bt);
    endtask

    task automatic pulse_ack();
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic       ok;
        int         dsel;
        checks   = 0;
        failures = 0;
        man_ack  = 1'b0;
        sb_en    = 1'b1;
        div      = 1;
        rst_n    = 1'b0;
        rxpin    = IL ^ DI;
        repeat (3) @(negedge clk);
        chk("rst_valid", rif.valid, 0);
        chk("rst_char", rif.char, 0);
        chk("rst_ferr", rif.ferr, 0);
        chk("rst_overrun", rif.overrun, 0);
        chk("rst_busy", rif.busy, 0);
        rst_n = 1'b1;
        drive_bits(IL, 2 * OS);
        chk("idle_no_start", rif.busy, 0);

        // Basic byte at one tick per clock.
        send_frame(8'hA5, 1'b1, 2, 1'b1);

        // Start glitch of four ticks must be rejected.
        div = 2;
        drive_bits(IL, OS * div);
        drive_bits(~IL, 4 * div);
        drive_bits(IL, 2 * OS * div);
        chk("glitch_busy", rif.busy, 0);
        chk("glitch_valid", rif.valid, 0);

        // Held break: one 0x00 with ferr, busy until the line recovers.
        begin
            exp_t e;
            e.data = 8'h00;
            e.ferr = 1'b1;
            sb.push_back(e);
        end
        drive_bits(~IL, 12 * OS * div);
        chk("break_busy", rif.busy, 1);
        drive_bits(IL, 2 * div + 4);
        chk("break_exit", rif.busy, 0);
        drive_bits(IL, 2 * OS * div);

        // Overrun and coincident ack, with the scoreboard paused.
        sb_en = 1'b0;
        div   = 1;
        drive_bits(IL, 2 * OS);
        fork
            send_frame(8'h11, 1'b1, 0, 1'b0);
            begin
                repeat (155) @(negedge clk);
                chk("latency_before", rif.valid, 0);
                @(negedge clk);
                chk("latency_rise", rif.valid, 1);
                chk("latency_busy", rif.busy, 0);
            end
        join
        send_frame(8'h22, 1'b1, 1, 1'b0);
        chk("ovr_char", rif.char, 8'h22);
        chk("ovr_flag", rif.overrun, 1);
        chk("ovr_valid", rif.valid, 1);
        pulse_ack();
        chk("ack_valid", rif.valid, 0);
        chk("ack_overrun", rif.overrun, 0);
        send_frame(8'h33, 1'b1, 1, 1'b0);
        chk("pre_coinc_valid", rif.valid, 1);
        fork
            send_frame(8'h44, 1'b1, 1, 1'b0);
            begin
                repeat (155) @(negedge clk);
                pulse_ack();
            end
        join
        chk("coinc_char", rif.char, 8'h44);
        chk("coinc_valid", rif.valid, 1);
        chk("coinc_overrun", rif.overrun, 0);
        pulse_ack();
        chk("coinc_ack_valid", rif.valid, 0);
        sb_en = 1'b1;

        // Corner bytes at one tick per four clocks.
        div = 4;
        drive_bits(IL, OS * div);
        send_frame(8'h00, 1'b1, 1, 1'b1);
        send_frame(8'hFF, 1'b1, 1, 1'b1);
        send_frame(8'h3C, 1'b1, 1, 1'b1);

        // Random bytes, tick rates, stop quality and inter-frame gaps.
        for (int n = 0; n < 20; n++) begin
            dsel = $urandom_range(0, 2);
            div  = (dsel == 0) ? 1 : (dsel == 1) ? 2 : 4;
            drive_bits(IL, $urandom_range(1, 40));
            d  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send_frame(d, ok, ok ? $urandom_range(0, 2) : $urandom_range(1, 2), 1'b1);
        end

        // Reset in the middle of 0x5A discards the partial byte.
        div = 2;
        drive_bits(IL, 2 * OS * div);
        d = 8'h5A;
        drive_bits(~IL, OS * div);
        for (int i = 0; i < 3; i++) drive_bits(d[i], OS * div);
        rst_n = 1'b0;
        rxpin = IL ^ DI;
        #1;
        chk("midrst_valid", rif.valid, 0);
        chk("midrst_char", rif.char, 0);
        chk("midrst_busy", rif.busy, 0);
        chk("midrst_ferr", rif.ferr, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive_bits(IL, 2 * OS * div);
        chk("postrst_valid", rif.valid, 0);
        send_frame(8'h81, 1'b1, 2, 1'b1);

        for (int i = 0; i < 3000 && (sb.size() != 0 || rif.valid); i++) @(negedge clk);
        chk("drain", sb.size(), 0);
        chk("final_valid", rif.valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
